alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  - Registered 12-bit arithmetic unit of the accumulator datapath.
//  - Combines accumulator AC with the shared Bus per a 3-bit opcode.
//  - Captures the result, and a zero flag for branch decisions, on the clock edge.
//  - Result drives the AC write-back path; Zflag feeds the control unit.
// PARAMETERS
//  reg_width  12  datapath width of AC, Bus and result (>=2)
// PORTS
//  clk            in   1          system clock, rising-edge active
//  reset          in   1          asynchronous, active-low reset
//  ALU_Operation  in   3          opcode, sampled on rising clk
//  AC             in   reg_width  accumulator operand (A)
//  Bus            in   reg_width  bus operand (B)
//  result         out  reg_width  registered operation result
//  Zflag          out  1          registered zero flag
// BEHAVIOUR
//  - Interface: one clock clk; reset is asynchronous and active-low.
//  - reset low: result=0 and Zflag=0 immediately, independent of clk.
//    Both outputs hold while reset is low.
//    First update is on the first rising clk after reset returns high.
//  - All updates occur on rising clk. Latency 1 cycle; no handshake.
//    Operands and opcode are sampled at the same edge.
//  - Opcodes; N = new result; arithmetic is modulo 2^reg_width:
//      000 IDLE  result, Zflag hold
//      001 PASS  N = Bus
//      010 ADD   N = AC + Bus; carry discarded
//      011 SUB   N = AC - Bus; two's complement wrap, borrow discarded
//      100 MUL   N = low reg_width bits of AC*Bus; upper bits discarded
//      101 INC   N = AC + 1; all-ones wraps to 0
//      110 ZERO  N = 0
//      111 reserved: hold, as IDLE (see CONFIGURATION)
//  - Zflag: on every non-hold op, Zflag <= (N == 0); on hold ops it holds.
//    Thus ZERO sets Zflag=1, and wrap to 0 (ADD/INC/MUL) sets Zflag=1.
//  - X/unknown opcode must not corrupt state: treat as hold.
//  - Outputs are driven only from registers; no combinational input->output path.
// CONFIGURATION
//  - ALU_EXT_OPS_EN defined: opcode 111 = AND, N = AC & Bus, Zflag updated as above.
//  - ALU_EXT_OPS_EN undefined: opcode 111 holds result and Zflag; no AND logic built.
// TESTING
//  - Reset: drive reset=0 mid-cycle -> result=0, Zflag=0 before the next clk edge.
//  - PASS: op=001, Bus=0x0C0 -> result=0x0C0, Zflag=0 one edge later.
//  - ADD: AC=0x402, Bus=0x0C8 -> result=0x4CA.
//    Also AC=0xFFF, Bus=0x001 -> result=0x000, Zflag=1.
//  - SUB: AC=8, Bus=5 -> result=3, Zflag=0.
//    Then AC=8, Bus=8 -> result=0, Zflag=1.
//    Then AC=0, Bus=1 -> result=0xFFF.
//  - MUL/INC: AC=8, Bus=9, op=100 -> result=0x048.
//    AC=8, op=101 -> result=9.
//    AC=0x040, Bus=0x040, op=100 -> result=0x000, Zflag=1.
//  - ZERO/IDLE/111: op=110 -> result=0, Zflag=1.
//    op=000 with changing AC/Bus -> outputs hold.
//    op=111: hold without ALU_EXT_OPS_EN; with it, AC=0xF0F, Bus=0x0FF -> result=0x00F.

Source files
------------

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- registered arithmetic unit of the accumulator datapath.
//
// Combines the accumulator operand AC with the shared Bus according to a
// 3-bit opcode and captures the result plus a zero flag on the rising clock.
// The result feeds the AC write-back path; Zflag feeds the control unit.
//
// Parameters:
//   reg_width      datapath width of AC, Bus and result (>= 2), default 12
//
// Ports:
//   clk            in   1          system clock, rising-edge active
//   reset          in   1          asynchronous, active-low reset
//   ALU_Operation  in   3          opcode, sampled on rising clk
//   AC             in   reg_width  accumulator operand (A)
//   Bus            in   reg_width  bus operand (B)
//   result         out  reg_width  registered operation result
//   Zflag          out  1          registered zero flag
//
// Interface timing: no handshake. Opcode and operands are sampled together on
// every rising edge and the outputs reflect them one cycle later.
//
// Opcodes: 000 IDLE (hold), 001 PASS, 010 ADD, 011 SUB, 100 MUL (low bits),
//          101 INC, 110 ZERO, 111 reserved (hold) or AND.
//
// Optional feature macro: ALU_EXT_OPS_EN -- when defined, opcode 111 performs
// AC & Bus; when undefined, opcode 111 holds and no AND logic is built.
// -----------------------------------------------------------------------------
module alu #(
    parameter int reg_width = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           ALU_Operation,
    input  logic [reg_width-1:0] AC,
    input  logic [reg_width-1:0] Bus,
    output logic [reg_width-1:0] result,
    output logic                 Zflag
);

    localparam logic [reg_width-1:0] ONE = reg_width'(1);

    logic [reg_width-1:0] result_q;
    logic [reg_width-1:0] result_d;
    logic                 zflag_q;
    logic                 zflag_d;
    logic [reg_width-1:0] new_val;
    logic                 update;

    // Operation decode. Anything not listed (IDLE, reserved 111 in the base
    // build, or an unknown opcode in simulation) falls to the default and
    // leaves the registers untouched.
    always_comb begin
        new_val = '0;
        update  = 1'b0;
        case (ALU_Operation)
            3'b001: begin new_val = Bus;       update = 1'b1; end
            3'b010: begin new_val = AC + Bus;  update = 1'b1; end
            3'b011: begin new_val = AC - Bus;  update = 1'b1; end
            // Product is evaluated at reg_width, keeping only the low bits.
            3'b100: begin new_val = AC * Bus;  update = 1'b1; end
            3'b101: begin new_val = AC + ONE;  update = 1'b1; end
            3'b110: begin new_val = '0;        update = 1'b1; end
`ifdef ALU_EXT_OPS_EN
            3'b111: begin new_val = AC & Bus;  update = 1'b1; end
`endif
            default: begin new_val = '0;       update = 1'b0; end
        endcase
    end

    always_comb begin
        result_d = result_q;
        zflag_d  = zflag_q;
        if (update) begin
            result_d = new_val;
            zflag_d  = (new_val == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            zflag_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zflag_q  <= zflag_d;
        end
    end

    assign result = result_q;
    assign Zflag  = zflag_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    localparam int W = 12;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         reset;
    logic [2:0]   ALU_Operation;
    logic [W-1:0] AC;
    logic [W-1:0] Bus;
    logic [W-1:0] result;
    logic         Zflag;

    int checks = 0;
    int errors = 0;

    // Reference state: what result/Zflag should hold right now.
    int exp_r = 0;
    int exp_z = 0;

    // Scoreboard of expected {Zflag, result} pairs, one per applied op.
    logic [W:0] exp_q[$];

    alu #(.reg_width(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .ALU_Operation (ALU_Operation),
        .AC            (AC),
        .Bus           (Bus),
        .result        (result),
        .Zflag         (Zflag)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: plain integer arithmetic reduced modulo 2^W.
    // Returns -1 when the opcode leaves the outputs unchanged.
    function automatic int model_op(int op, int a, int b);
        case (op)
            1: return b;
            2: return (a + b) % MOD;
            3: return (a - b + MOD) % MOD;
            4: return (a * b) % MOD;
            5: return (a + 1) % MOD;
            6: return 0;
`ifdef ALU_EXT_OPS_EN
            7: return a & b;
`endif
            default: return -1;
        endcase
    endfunction

    task automatic check_r(string tag, int want);
        checks++;
        assert (result === W'(want)) else begin
            errors++;
            $error("FAIL %s result got %h expected %h", tag, result, W'(want));
        end
    endtask

    task automatic check_z(string tag, int want);
        checks++;
        assert (Zflag === 1'(want)) else begin
            errors++;
            $error("FAIL %s Zflag got %0d expected %0d", tag, Zflag, want);
        end
    endtask

    // Driver: apply one op at the falling edge, sample 1 time unit after the
    // capturing rising edge and compare against the scoreboard entry.
    task automatic step(string tag, int op, int a, int b);
        int n;
        logic [W:0] e;
        @(negedge clk);
        ALU_Operation = 3'(op);
        AC            = W'(a);
        Bus           = W'(b);
        n = model_op(op, a, b);
        if (n >= 0) begin
            exp_r = n;
            exp_z = (n == 0) ? 1 : 0;
        end
        exp_q.push_back({1'(exp_z), W'(exp_r)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_r(tag, int'(e[W-1:0]));
        check_z(tag, int'(e[W]));
    endtask

    // Reset asserted mid-cycle: outputs must clear before the next edge and
    // stay cleared across an edge that would otherwise load a value.
    task automatic reset_pulse(string tag);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_r({tag, "_async"}, 0);
        check_z({tag, "_async"}, 0);
        ALU_Operation = 3'b001;
        Bus           = 12'h5A5;
        @(posedge clk);
        #1;
        check_r({tag, "_hold"}, 0);
        check_z({tag, "_hold"}, 0);
        @(negedge clk);
        ALU_Operation = 3'b000;
        reset = 1'b1;
        exp_r = 0;
        exp_z = 0;
    endtask

    initial begin
        reset         = 1'b0;
        ALU_Operation = 3'b000;
        AC            = '0;
        Bus           = '0;
        repeat (2) @(posedge clk);
        #1;
        check_r("por", 0);
        check_z("por", 0);
        @(negedge clk);
        reset = 1'b1;

        step("pass",      1, 12'h000, 12'h0C0);
        reset_pulse("rst_nonzero");
        step("add",       2, 12'h402, 12'h0C8);
        step("add_wrap",  2, 12'hFFF, 12'h001);
        step("sub",       3, 8, 5);
        step("sub_zero",  3, 8, 8);
        step("sub_wrap",  3, 0, 1);
        step("mul",       4, 8, 9);
        step("inc",       5, 8, 0);
        step("inc_wrap",  5, 12'hFFF, 0);
        step("mul_wrap",  4, 12'h040, 12'h040);
        step("pass2",     1, 0, 12'h321);
        step("zero",      6, 12'h123, 12'h456);
        step("idle_a",    0, 12'hABC, 12'h111);
        step("idle_b",    0, 12'h001, 12'hFFE);
        step("pass3",     1, 0, 12'h777);
        step("op7",       7, 12'hF0F, 12'h0FF);
        step("op7_b",     7, 12'h000, 12'h0F0);
        step("zero2",     6, 0, 0);
        reset_pulse("rst_zflag");

        for (int i = 0; i < 300; i++) begin
            int op;
            int a;
            int b;
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, MOD - 1));
            b  = int'($urandom_range(0, MOD - 1));
            // Bias some operands toward edge values to hit wrap cases.
            if ($urandom_range(0, 3) == 0) a = (($urandom_range(0, 1) == 0) ? 0 : MOD - 1);
            if ($urandom_range(0, 3) == 0) b = (($urandom_range(0, 1) == 0) ? 1 : a);
            step("rand", op, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
